uart_rx_param: RTL and testbench

Parametrised UART receiver, the next generation of the fixed 8-bit front-end receiver that feeds the encoder in the transceiver chain. Adds:
- configurable data width, parity mode and stop-bit count
- start-bit glitch rejection
- parity and framing error flags
- an enable that can abort a frame in progress

It sits between the serial input pin and the encoder, and delivers one word per frame with a single-cycle valid strobe.

---
 rtl/uart_rx_param.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver feeding the transceiver encoder. Detects a
//   start bit on the synchronised serial line, samples each bit in the
//   middle of its bit period, checks optional parity and 1 or 2 stop bits,
//   and delivers one word per frame with a single-cycle strobe.
//
// Parameters
//   CLKS_PER_BIT : clocks per serial bit, even and >= 4
//   DATA_WIDTH   : data bits per frame, 5..9, LSB first
//   PARITY       : 0 none, 1 odd, 2 even
//   STOP_BITS    : stop bits checked, 1 or 2
//
// Ports
//   clk        in   system clock, rising edge
//   arstn      in   asynchronous active-low reset
//   en         in   receiver enable; low aborts a frame in progress
//   data       in   serial line, idle high, asynchronous to clk
//   rx_data    out  received word (held until the next rx_valid)
//   rx_valid   out  one-cycle strobe: rx_data and error flags updated
//   parity_err out  parity mismatch on last delivered word
//   frame_err  out  a stop bit sampled 0 on last delivered word
//   active     out  high while a frame is being received
//
// Build option
//   UART_RX_MAJORITY_EN : when defined, each bit sample is the majority of
//   the synchronised line at the sample edge and the two edges before it.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a low level on the synchronised line
// START  | half a bit period to the start-bit sample (glitch check)
// DATA   | sampling DATA_WIDTH data bits, LSB first
// PARITY | sampling and checking the parity bit
// STOP   | sampling STOP_BITS stop bits
// DONE   | one cycle: word and flags presented with rx_valid

module uart_rx_param #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  en,
  input  logic                  data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);
  localparam logic          ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic                  sync1, rxs;
  logic                  samp;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_err_int, frm_err_int;
  logic                  tick;
  logic                  exp_par;

  // Synchroniser resets to the idle (high) line level so no false start
  // bit is seen coming out of reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= data;
      rxs   <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rxs_d1, rxs_d2;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rxs_d1 <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      rxs_d1 <= rxs;
      rxs_d2 <= rxs_d1;
    end
  end

  assign samp = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
`else
  assign samp = rxs;
`endif

  // The first sample lands half a bit after the start edge, every later
  // one a full bit after the previous sample.
  assign tick    = (state == S_START) ? (cnt == HALF_TC) : (cnt == FULL_TC);
  assign exp_par = (^shreg) ^ ODD;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_valid  = 1'b0;
    active    = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && !rxs) state_nxt = S_START;
      end
      S_START: begin
        active = 1'b1;
        if (!en)       state_nxt = S_IDLE;
        else if (tick) state_nxt = samp ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        active = 1'b1;
        if (!en) state_nxt = S_IDLE;
        else if (tick && bit_cnt == LAST_BIT)
          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        active = 1'b1;
        if (!en)       state_nxt = S_IDLE;
        else if (tick) state_nxt = S_STOP;
      end
      S_STOP: begin
        active = 1'b1;
        if (!en) state_nxt = S_IDLE;
        else if (tick && stop_cnt == LAST_STOP) state_nxt = S_DONE;
      end
      S_DONE: begin
        rx_valid  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      cnt         <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shreg       <= '0;
      par_err_int <= 1'b0;
      frm_err_int <= 1'b0;
      rx_data     <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (state_nxt == S_START) begin
          cnt         <= '0;
          bit_cnt     <= '0;
          stop_cnt    <= 1'b0;
          par_err_int <= 1'b0;
          frm_err_int <= 1'b0;
        end
      end else if (state != S_DONE) begin
        cnt <= tick ? '0 : cnt + CW'(1);
      end

      if (state == S_DATA && tick) begin
        shreg   <= {samp, shreg[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + BW'(1);
      end

      if (state == S_PARITY && tick)
        par_err_int <= (samp != exp_par);

      if (state == S_STOP && tick) begin
        if (!samp) frm_err_int <= 1'b1;
        stop_cnt <= stop_cnt + 1'b1;
      end

      // Outputs are loaded on the edge into DONE (abort has priority), so
      // they are already valid during the rx_valid cycle. The last stop
      // sample is folded in directly since frm_err_int updates on this edge.
      if (state == S_STOP && state_nxt == S_DONE) begin
        rx_data    <= shreg;
        parity_err <= par_err_int;
        frame_err  <= frm_err_int | ~samp;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       arstn;
  logic       en;
  logic       line [3];
  logic [7:0] rxd0, rxd1;
  logic [8:0] rxd2;
  logic [2:0] vld, perr, ferr, act;

  int total = 0;
  int bad   = 0;
  int vcnt    [3] = '{0, 0, 0};
  int act_cyc [3] = '{0, 0, 0};
  int a0;

  always #5 clk = ~clk;

  // Defaults: 8 data bits, no parity, 1 stop bit
  uart_rx_param #(.CLKS_PER_BIT(CPB)) dut0 (
    .clk(clk), .arstn(arstn), .en(en), .data(line[0]),
    .rx_data(rxd0), .rx_valid(vld[0]), .parity_err(perr[0]),
    .frame_err(ferr[0]), .active(act[0]));

  // Even parity
  uart_rx_param #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut1 (
    .clk(clk), .arstn(arstn), .en(en), .data(line[1]),
    .rx_data(rxd1), .rx_valid(vld[1]), .parity_err(perr[1]),
    .frame_err(ferr[1]), .active(act[1]));

  // 9 data bits, 2 stop bits
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(9), .STOP_BITS(2)) dut2 (
    .clk(clk), .arstn(arstn), .en(en), .data(line[2]),
    .rx_data(rxd2), .rx_valid(vld[2]), .parity_err(perr[2]),
    .frame_err(ferr[2]), .active(act[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i]) vcnt[i]++;
      if (act[i]) act_cyc[i]++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives bits[0..n-1] one bit period each, then returns the line to idle.
  task automatic send(input int idx, input int n, input logic [15:0] bits);
    for (int i = 0; i < n; i++) begin
      line[idx] = bits[i];
      idle(CPB);
    end
    line[idx] = 1'b1;
  endtask

  initial begin
    arstn = 1'b0;
    en    = 1'b0;
    for (int i = 0; i < 3; i++) line[i] = 1'b1;
    idle(3);
    check("rst_rx_data", rxd0, 0);
    check("rst_rx_valid", vld[0], 0);
    check("rst_parity_err", perr[0], 0);
    check("rst_frame_err", ferr[0], 0);
    check("rst_active", act[0], 0);
    arstn = 1'b1;
    en    = 1'b1;
    idle(4);

    // Start glitch: 2 cycles low, rejected at the half-bit sample
    a0 = act_cyc[0];
    line[0] = 1'b0;
    idle(2);
    line[0] = 1'b1;
    idle(12);
    check("glitch_active_cycles", act_cyc[0] - a0, 4);
    check("glitch_no_valid", vcnt[0], 0);
    check("glitch_active_low", act[0], 0);
    check("glitch_rx_data", rxd0, 0);

    // Clean frame 0xA5
    send(0, 10, {6'b0, 1'b1, 8'hA5, 1'b0});
    idle(4);
    check("a5_valid_cnt", vcnt[0], 1);
    check("a5_rx_data", rxd0, 8'hA5);
    check("a5_parity_err", perr[0], 0);
    check("a5_frame_err", ferr[0], 0);
    check("a5_active", act[0], 0);

    // Even parity, 0x3C: wrong parity bit then correct one
    send(1, 11, {5'b0, 1'b1, 1'b1, 8'h3C, 1'b0});
    idle(4);
    check("par_bad_cnt", vcnt[1], 1);
    check("par_bad_data", rxd1, 8'h3C);
    check("par_bad_perr", perr[1], 1);
    check("par_bad_ferr", ferr[1], 0);
    send(1, 11, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0});
    idle(4);
    check("par_ok_cnt", vcnt[1], 2);
    check("par_ok_data", rxd1, 8'h3C);
    check("par_ok_perr", perr[1], 0);

    // Framing error on 0x5A, then clean 0x0F
    send(0, 10, {6'b0, 1'b0, 8'h5A, 1'b0});
    idle(14);
    check("ferr_cnt", vcnt[0], 2);
    check("ferr_data", rxd0, 8'h5A);
    check("ferr_flag", ferr[0], 1);
    check("ferr_perr", perr[0], 0);
    check("ferr_active", act[0], 0);
    send(0, 10, {6'b0, 1'b1, 8'h0F, 1'b0});
    idle(4);
    check("f0_cnt", vcnt[0], 3);
    check("f0_data", rxd0, 8'h0F);
    check("f0_ferr", ferr[0], 0);

    // Reset during data bit 3 of 0x66
    send(0, 4, {12'b0, 3'b110, 1'b0});
    line[0] = 1'b0;
    idle(4);
    check("rstmid_active_before", act[0], 1);
    arstn = 1'b0;
    #1;
    check("rstmid_rx_data", rxd0, 0);
    check("rstmid_active", act[0], 0);
    check("rstmid_valid", vld[0], 0);
    check("rstmid_ferr", ferr[0], 0);
    line[0] = 1'b1;
    idle(2);
    arstn = 1'b1;
    idle(12);
    check("rstmid_no_valid", vcnt[0], 3);
    send(0, 10, {6'b0, 1'b1, 8'h81, 1'b0});
    idle(4);
    check("x81_cnt", vcnt[0], 4);
    check("x81_data", rxd0, 8'h81);
    check("x81_ferr", ferr[0], 0);

    // en dropped during data bit 4 of 0xC3
    send(0, 5, {11'b0, 4'b0011, 1'b0});
    line[0] = 1'b0;
    idle(4);
    check("abort_active_before", act[0], 1);
    en = 1'b0;
    idle(2);
    check("abort_active", act[0], 0);
    line[0] = 1'b1;
    idle(CPB * 6);
    en = 1'b1;
    idle(4);
    check("abort_no_valid", vcnt[0], 4);
    check("abort_data_held", rxd0, 8'h81);

    // 9-bit words, 2 stop bits, back to back
    send(2, 12, {4'b0, 2'b11, 9'h1FF, 1'b0});
    check("w9_first_data", rxd2, 9'h1FF);
    check("w9_first_cnt", vcnt[2], 1);
    send(2, 12, {4'b0, 2'b11, 9'h001, 1'b0});
    idle(4);
    check("w9_second_cnt", vcnt[2], 2);
    check("w9_second_data", rxd2, 9'h001);
    check("w9_second_ferr", ferr[2], 0);
    check("w9_second_perr", perr[2], 0);
    send(2, 12, {4'b0, 2'b01, 9'h0AA, 1'b0});
    idle(16);
    check("w9_stop2_cnt", vcnt[2], 3);
    check("w9_stop2_data", rxd2, 9'h0AA);
    check("w9_stop2_ferr", ferr[2], 1);
    check("w9_stop2_active", act[2], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
